// File: rtl/pe_pass_controller.sv
// ---------------------------------------------------------------------------
// pe_pass_controller
//
// Sequences one processing pass of a single PE wrapper. On an accepted start
// it latches the pass geometry and the four word counts, enables the PE clock
// gate, loads filter words, then ifmap words, and streams input psums and
// output psums between the upstream/downstream valid-ready channels and the
// PE FIFO ports. A one-cycle done pulse marks the end of the pass.
//
// Ports
//   clk, reset             clock, asynchronous active-low reset
//   start, abort           begin a pass (IDLE only) / synchronous abort
//   cfg_in, cfg_out        packed PE geometry in / latched geometry to the PE
//   n_filter .. n_opsum    word counts for the pass, latched on start
//   pe_enable, pe_busy     PE clock-gate enable / PE busy flag
//   busy, done             controller busy / one-cycle completion pulse
//   filter_*, ifmap_*,     upstream valid-ready channel and PE FIFO push
//   ipsum_*                port for each input stream (data passes through)
//   opsum_fifo_*, pop_opsum  PE opsum FIFO (first-word fall-through)
//   opsum_data/valid/ready downstream opsum channel
// ---------------------------------------------------------------------------
module pe_pass_controller #(
  parameter int DATA_WIDTH_IFMAP  = 16,
  parameter int DATA_WIDTH_FILTER = 64,
  parameter int DATA_WIDTH_PSUM   = 64,
  parameter int CNT_WIDTH         = 16,
  parameter int CFG_WIDTH         = 33
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [CFG_WIDTH-1:0]         cfg_in,
  input  logic [CNT_WIDTH-1:0]         n_filter,
  input  logic [CNT_WIDTH-1:0]         n_ifmap,
  input  logic [CNT_WIDTH-1:0]         n_ipsum,
  input  logic [CNT_WIDTH-1:0]         n_opsum,
  output logic [CFG_WIDTH-1:0]         cfg_out,
  output logic                         pe_enable,
  input  logic                         pe_busy,
  output logic                         busy,
  output logic                         done,
  input  logic [DATA_WIDTH_FILTER-1:0] filter_in,
  input  logic                         filter_valid,
  output logic                         filter_ready,
  output logic                         push_filter,
  input  logic                         filter_fifo_full,
  output logic [DATA_WIDTH_FILTER-1:0] filter_out,
  input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_in,
  input  logic                         ifmap_valid,
  output logic                         ifmap_ready,
  output logic                         push_ifmap,
  input  logic                         ifmap_fifo_full,
  output logic [DATA_WIDTH_IFMAP-1:0]  ifmap_out,
  input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_in,
  input  logic                         ipsum_valid,
  output logic                         ipsum_ready,
  output logic                         push_ipsum,
  input  logic                         ipsum_fifo_full,
  output logic [DATA_WIDTH_PSUM-1:0]   ipsum_out,
  input  logic [DATA_WIDTH_PSUM-1:0]   opsum_fifo_data,
  input  logic                         opsum_fifo_empty,
  output logic                         pop_opsum,
  output logic [DATA_WIDTH_PSUM-1:0]   opsum_data,
  output logic                         opsum_valid,
  input  logic                         opsum_ready
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FILTER,
    LOAD_IFMAP,
    STREAM,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state;
  logic [CFG_WIDTH-1:0] cfg_q;
  logic [CNT_WIDTH-1:0] n_filter_q, n_ifmap_q, n_ipsum_q, n_opsum_q;
  logic [CNT_WIDTH-1:0] cnt_filter, cnt_ifmap, cnt_ipsum, cnt_opsum;
  logic                 pe_enable_q, busy_q, done_q;

  logic filter_fire, ifmap_fire, ipsum_fire, opsum_avail, opsum_fire;
  logic filter_last, ifmap_last, stream_complete;

  // Handshake decode. Abort masks every transfer in the cycle it is raised,
  // and the count compare keeps surplus upstream words stalled.
  always_comb begin
    filter_fire = filter_valid & ~filter_fifo_full & ~abort &
                  (state == LOAD_FILTER) & (cnt_filter < n_filter_q);
    ifmap_fire  = ifmap_valid & ~ifmap_fifo_full & ~abort &
                  (state == LOAD_IFMAP) & (cnt_ifmap < n_ifmap_q);
    ipsum_fire  = ipsum_valid & ~ipsum_fifo_full & ~abort &
                  ((state == LOAD_IFMAP) | (state == STREAM)) &
                  (cnt_ipsum < n_ipsum_q);
    opsum_avail = ~opsum_fifo_empty & ~abort & (state == STREAM) &
                  (cnt_opsum < n_opsum_q);
    opsum_fire  = opsum_avail & opsum_ready;

    // The push that brings a count up to its target ends the load phase.
    filter_last = filter_fire & ((cnt_filter + CNT_ONE) == n_filter_q);
    ifmap_last  = ifmap_fire & ((cnt_ifmap + CNT_ONE) == n_ifmap_q);

    // Completion looks only at registered counts, so the final pushes and
    // pops must have landed before the pass can finish.
    stream_complete = (cnt_ipsum == n_ipsum_q) & (cnt_opsum == n_opsum_q) &
                      ~pe_busy;
  end

  assign filter_ready = filter_fire;
  assign push_filter  = filter_fire;
  assign filter_out   = filter_in;
  assign ifmap_ready  = ifmap_fire;
  assign push_ifmap   = ifmap_fire;
  assign ifmap_out    = ifmap_in;
  assign ipsum_ready  = ipsum_fire;
  assign push_ipsum   = ipsum_fire;
  assign ipsum_out    = ipsum_in;
  assign opsum_valid  = opsum_avail;
  assign pop_opsum    = opsum_fire;
  assign opsum_data   = opsum_fifo_data;

  assign cfg_out   = cfg_q;
  assign pe_enable = pe_enable_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Pass sequencer with registered status outputs. Abort overrides every
  // transition but leaves the latched geometry on cfg_out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cfg_q       <= '0;
      n_filter_q  <= '0;
      n_ifmap_q   <= '0;
      n_ipsum_q   <= '0;
      n_opsum_q   <= '0;
      cnt_filter  <= '0;
      cnt_ifmap   <= '0;
      cnt_ipsum   <= '0;
      cnt_opsum   <= '0;
      pe_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      cnt_filter  <= '0;
      cnt_ifmap   <= '0;
      cnt_ipsum   <= '0;
      cnt_opsum   <= '0;
      pe_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (filter_fire) cnt_filter <= cnt_filter + CNT_ONE;
      if (ifmap_fire)  cnt_ifmap  <= cnt_ifmap + CNT_ONE;
      if (ipsum_fire)  cnt_ipsum  <= cnt_ipsum + CNT_ONE;
      if (opsum_fire)  cnt_opsum  <= cnt_opsum + CNT_ONE;

      case (state)
        IDLE: begin
          if (start) begin
            cfg_q       <= cfg_in;
            n_filter_q  <= n_filter;
            n_ifmap_q   <= n_ifmap;
            n_ipsum_q   <= n_ipsum;
            n_opsum_q   <= n_opsum;
            cnt_filter  <= '0;
            cnt_ifmap   <= '0;
            cnt_ipsum   <= '0;
            cnt_opsum   <= '0;
            pe_enable_q <= 1'b1;
            busy_q      <= 1'b1;
            if (n_filter != '0)
              state <= LOAD_FILTER;
            else if (n_ifmap != '0)
              state <= LOAD_IFMAP;
            else
              state <= STREAM;
          end
        end
        LOAD_FILTER: begin
          if (filter_last)
            state <= (n_ifmap_q != '0) ? LOAD_IFMAP : STREAM;
        end
        LOAD_IFMAP: begin
          if (ifmap_last)
            state <= STREAM;
        end
        STREAM: begin
          if (stream_complete) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          pe_enable_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          pe_enable_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_pass_controller.sv
// ---------------------------------------------------------------------------
// tb_pe_pass_controller
//
// Directed and randomized passes through pe_pass_controller. The reference
// model tracks a pass purely as progress: words moved per channel against the
// latched counts, plus "pass active" and "done cycle" flags. The load phase a
// pass is in follows from which counts are still short of their targets.
// ---------------------------------------------------------------------------
module tb_pe_pass_controller;

  localparam int DWI = 16;
  localparam int DWF = 64;
  localparam int DWP = 64;
  localparam int CW  = 16;
  localparam int GW  = 33;

  logic            clk;
  logic            reset;
  logic            start;
  logic            abort;
  logic [GW-1:0]   cfg_in;
  logic [CW-1:0]   n_filter, n_ifmap, n_ipsum, n_opsum;
  logic [GW-1:0]   cfg_out;
  logic            pe_enable, pe_busy, busy, done;
  logic [DWF-1:0]  filter_in, filter_out;
  logic            filter_valid, filter_ready, push_filter, filter_fifo_full;
  logic [DWI-1:0]  ifmap_in, ifmap_out;
  logic            ifmap_valid, ifmap_ready, push_ifmap, ifmap_fifo_full;
  logic [DWP-1:0]  ipsum_in, ipsum_out;
  logic            ipsum_valid, ipsum_ready, push_ipsum, ipsum_fifo_full;
  logic [DWP-1:0]  opsum_fifo_data, opsum_data;
  logic            opsum_fifo_empty, pop_opsum, opsum_valid, opsum_ready;

  pe_pass_controller #(
    .DATA_WIDTH_IFMAP(DWI), .DATA_WIDTH_FILTER(DWF), .DATA_WIDTH_PSUM(DWP),
    .CNT_WIDTH(CW), .CFG_WIDTH(GW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_in(cfg_in), .n_filter(n_filter), .n_ifmap(n_ifmap),
    .n_ipsum(n_ipsum), .n_opsum(n_opsum), .cfg_out(cfg_out),
    .pe_enable(pe_enable), .pe_busy(pe_busy), .busy(busy), .done(done),
    .filter_in(filter_in), .filter_valid(filter_valid),
    .filter_ready(filter_ready), .push_filter(push_filter),
    .filter_fifo_full(filter_fifo_full), .filter_out(filter_out),
    .ifmap_in(ifmap_in), .ifmap_valid(ifmap_valid),
    .ifmap_ready(ifmap_ready), .push_ifmap(push_ifmap),
    .ifmap_fifo_full(ifmap_fifo_full), .ifmap_out(ifmap_out),
    .ipsum_in(ipsum_in), .ipsum_valid(ipsum_valid),
    .ipsum_ready(ipsum_ready), .push_ipsum(push_ipsum),
    .ipsum_fifo_full(ipsum_fifo_full), .ipsum_out(ipsum_out),
    .opsum_fifo_data(opsum_fifo_data), .opsum_fifo_empty(opsum_fifo_empty),
    .pop_opsum(pop_opsum), .opsum_data(opsum_data),
    .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus knobs (percentages are 0..100)
  int unsigned k_valid_pct, k_full_pct, k_empty_pct, k_ready_pct;
  bit          k_start, k_abort, k_pe_busy, k_force_ffull, k_noise;

  // Reference model of the pass
  bit          m_active, m_done;
  logic [GW-1:0] m_cfg;
  int          m_nf, m_ni, m_np, m_no;
  int          m_cf, m_ci, m_cp, m_co;
  bit          e_filter, e_ifmap, e_ipsum, e_opv, e_pop, e_stream;

  // Per-pass observed event counts
  int pc_filter, pc_ifmap, pc_ipsum, pc_opsum, pc_done;

  task automatic checkVal(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Randomized channel activity, directed control from the knobs.
  task automatic applyStimulus();
    filter_valid     = ($urandom_range(99) < k_valid_pct);
    ifmap_valid      = ($urandom_range(99) < k_valid_pct);
    ipsum_valid      = ($urandom_range(99) < k_valid_pct);
    filter_fifo_full = k_force_ffull || ($urandom_range(99) < k_full_pct);
    ifmap_fifo_full  = ($urandom_range(99) < k_full_pct);
    ipsum_fifo_full  = ($urandom_range(99) < k_full_pct);
    opsum_fifo_empty = ($urandom_range(99) < k_empty_pct);
    opsum_ready      = ($urandom_range(99) < k_ready_pct);
    filter_in        = {$urandom, $urandom};
    ifmap_in         = DWI'($urandom);
    ipsum_in         = {$urandom, $urandom};
    opsum_fifo_data  = {$urandom, $urandom};
    start            = k_start || (k_noise && ($urandom_range(3) == 0));
    abort            = k_abort;
    pe_busy          = k_pe_busy;
    if (k_noise) begin
      cfg_in   = GW'({$urandom, $urandom});
      n_filter = CW'($urandom);
      n_ifmap  = CW'($urandom);
      n_ipsum  = CW'($urandom);
      n_opsum  = CW'($urandom);
    end
  endtask

  task automatic computeExpected();
    bit live, ld_f, ld_i;
    live     = m_active && !m_done;
    ld_f     = live && (m_cf < m_nf);
    ld_i     = live && (m_cf == m_nf) && (m_ci < m_ni);
    e_stream = live && (m_cf == m_nf) && (m_ci == m_ni);
    e_filter = ld_f && filter_valid && !filter_fifo_full && !abort;
    e_ifmap  = ld_i && ifmap_valid && !ifmap_fifo_full && !abort;
    e_ipsum  = (ld_i || e_stream) && (m_cp < m_np) && ipsum_valid &&
               !ipsum_fifo_full && !abort;
    e_opv    = e_stream && (m_co < m_no) && !opsum_fifo_empty && !abort;
    e_pop    = e_opv && opsum_ready;
  endtask

  task automatic checkOutput();
    computeExpected();
    checkVal("filter_ready", 64'(filter_ready), 64'(e_filter));
    checkVal("push_filter",  64'(push_filter),  64'(e_filter));
    checkVal("filter_out",   64'(filter_out),   64'(filter_in));
    checkVal("ifmap_ready",  64'(ifmap_ready),  64'(e_ifmap));
    checkVal("push_ifmap",   64'(push_ifmap),   64'(e_ifmap));
    checkVal("ifmap_out",    64'(ifmap_out),    64'(ifmap_in));
    checkVal("ipsum_ready",  64'(ipsum_ready),  64'(e_ipsum));
    checkVal("push_ipsum",   64'(push_ipsum),   64'(e_ipsum));
    checkVal("ipsum_out",    64'(ipsum_out),    64'(ipsum_in));
    checkVal("opsum_valid",  64'(opsum_valid),  64'(e_opv));
    checkVal("pop_opsum",    64'(pop_opsum),    64'(e_pop));
    checkVal("opsum_data",   64'(opsum_data),   64'(opsum_fifo_data));
    checkVal("busy",         64'(busy),         64'(m_active));
    checkVal("pe_enable",    64'(pe_enable),    64'(m_active));
    checkVal("done",         64'(done),         64'(m_done));
    checkVal("cfg_out",      64'(cfg_out),      64'(m_cfg));
  endtask

  // Advance the model across the coming clock edge.
  task automatic advanceModel();
    bit complete;
    if (abort) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (m_done) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_cfg    = cfg_in;
        m_nf = int'(n_filter); m_ni = int'(n_ifmap);
        m_np = int'(n_ipsum);  m_no = int'(n_opsum);
        m_cf = 0; m_ci = 0; m_cp = 0; m_co = 0;
      end
    end else begin
      complete = e_stream && (m_cp == m_np) && (m_co == m_no) && !pe_busy;
      if (e_filter) m_cf++;
      if (e_ifmap)  m_ci++;
      if (e_ipsum)  m_cp++;
      if (e_pop)    m_co++;
      if (complete) m_done = 1'b1;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    if (push_filter === 1'b1) pc_filter++;
    if (push_ifmap  === 1'b1) pc_ifmap++;
    if (push_ipsum  === 1'b1) pc_ipsum++;
    if (pop_opsum   === 1'b1) pc_opsum++;
    if (done        === 1'b1) pc_done++;
    advanceModel();
  endtask

  task automatic startPass(input logic [GW-1:0] cfg, input int nf, input int ni,
                           input int np, input int no);
    cfg_in   = cfg;
    n_filter = CW'(nf);
    n_ifmap  = CW'(ni);
    n_ipsum  = CW'(np);
    n_opsum  = CW'(no);
    pc_filter = 0; pc_ifmap = 0; pc_ipsum = 0; pc_opsum = 0; pc_done = 0;
    k_pe_busy = 1'b0;
    k_start   = 1'b1;
    stepCycle();
    k_start   = 1'b0;
  endtask

  // Run the current pass to completion. With busy_hold>0, pe_busy stays high
  // throughout and for busy_hold cycles after every count is satisfied.
  task automatic finishPass(input int busy_hold, input int stall_from,
                            input int stall_len, input bit rand_busy);
    int  cyc, hold, c_fall, c_done, done_before;
    bit  counts_met;
    cyc = 0; hold = busy_hold; c_fall = -1; c_done = -1;
    while (m_active && cyc < 3000) begin
      counts_met = (m_cf == m_nf) && (m_ci == m_ni) &&
                   (m_cp == m_np) && (m_co == m_no);
      if (counts_met) begin
        if (hold > 0) begin
          k_pe_busy = 1'b1;
          hold--;
        end else begin
          k_pe_busy = 1'b0;
          if (c_fall < 0) c_fall = cyc;
        end
      end else if (busy_hold > 0) begin
        k_pe_busy = 1'b1;
      end else begin
        k_pe_busy = rand_busy ? 1'($urandom_range(1)) : 1'b0;
      end
      k_force_ffull = (cyc >= stall_from) && (cyc < stall_from + stall_len);
      done_before = pc_done;
      stepCycle();
      if (pc_done != done_before && c_done < 0) c_done = cyc;
      cyc++;
    end
    k_force_ffull = 1'b0;
    k_noise       = 1'b0;
    k_pe_busy     = 1'b0;
    checkVal("pass_timeout", 64'(m_active), 64'(0));
    checkVal("done_pulses",  64'(pc_done),   64'(1));
    checkVal("filter_words", 64'(pc_filter), 64'(m_nf));
    checkVal("ifmap_words",  64'(pc_ifmap),  64'(m_ni));
    checkVal("ipsum_words",  64'(pc_ipsum),  64'(m_np));
    checkVal("opsum_words",  64'(pc_opsum),  64'(m_no));
    if (busy_hold > 0)
      checkVal("busy_hold_done_cycle", 64'(c_done), 64'(c_fall + 1));
  endtask

  task automatic setKnobs(input int unsigned v, input int unsigned f,
                          input int unsigned e, input int unsigned r);
    k_valid_pct = v; k_full_pct = f; k_empty_pct = e; k_ready_pct = r;
  endtask

  initial begin
    int guard;
    logic [GW-1:0] cfg_a;

    // Reset state
    k_start = 1'b0; k_abort = 1'b0; k_pe_busy = 1'b0;
    k_force_ffull = 1'b0; k_noise = 1'b0;
    setKnobs(0, 0, 100, 0);
    m_active = 1'b0; m_done = 1'b0; m_cfg = '0;
    m_nf = 0; m_ni = 0; m_np = 0; m_no = 0;
    m_cf = 0; m_ci = 0; m_cp = 0; m_co = 0;
    cfg_in = '0; n_filter = '0; n_ifmap = '0; n_ipsum = '0; n_opsum = '0;
    reset = 1'b0;
    applyStimulus();
    #2;
    checkOutput();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    $display("[TB] reset released");

    // Basic pass, everything always ready
    setKnobs(100, 0, 0, 100);
    startPass(33'h1_2345_6789, 3, 4, 2, 2);
    finishPass(0, 1 << 30, 0, 1'b0);

    // Filter FIFO backpressure for 5 cycles mid-load
    startPass(33'h0_0F0F_F0F0, 3, 4, 2, 2);
    finishPass(0, 1, 5, 1'b0);

    // Zero counts: straight into streaming, one opsum word
    startPass(33'h1_FFFF_0001, 0, 0, 0, 1);
    finishPass(0, 1 << 30, 0, 1'b0);

    // PE stays busy for 10 cycles after the counts are met
    startPass(33'h0_AAAA_5555, 2, 2, 3, 3);
    finishPass(10, 1 << 30, 0, 1'b0);

    // Abort during the ifmap load after two words
    cfg_a = 33'h1_5A5A_A5A5;
    startPass(cfg_a, 0, 6, 3, 2);
    guard = 0;
    while (m_ci < 2 && guard < 50) begin
      stepCycle();
      guard++;
    end
    k_abort = 1'b1;
    stepCycle();
    k_abort = 1'b0;
    stepCycle();
    checkVal("abort_busy",     64'(busy),    64'(0));
    checkVal("abort_cfg_hold", 64'(cfg_out), 64'(cfg_a));

    // A fresh start after the abort completes a full pass
    startPass(33'h0_1357_9BDF, 2, 5, 4, 3);
    finishPass(0, 1 << 30, 0, 1'b0);

    // Asynchronous reset while streaming
    setKnobs(100, 0, 100, 100);
    startPass(33'h1_0000_BEEF, 1, 1, 2, 3);
    guard = 0;
    while (!(m_cf == m_nf && m_ci == m_ni) && guard < 50) begin
      stepCycle();
      guard++;
    end
    stepCycle();
    stepCycle();
    @(negedge clk);
    applyStimulus();
    #2 reset = 1'b0;
    #1;
    checkVal("rst_busy",        64'(busy),         64'(0));
    checkVal("rst_pe_enable",   64'(pe_enable),    64'(0));
    checkVal("rst_done",        64'(done),         64'(0));
    checkVal("rst_cfg_out",     64'(cfg_out),      64'(0));
    checkVal("rst_filter_rdy",  64'(filter_ready), 64'(0));
    checkVal("rst_push_ifmap",  64'(push_ifmap),   64'(0));
    checkVal("rst_ipsum_rdy",   64'(ipsum_ready),  64'(0));
    checkVal("rst_push_ipsum",  64'(push_ipsum),   64'(0));
    checkVal("rst_opsum_valid", 64'(opsum_valid),  64'(0));
    checkVal("rst_pop_opsum",   64'(pop_opsum),    64'(0));
    m_active = 1'b0; m_done = 1'b0; m_cfg = '0;
    @(negedge clk);
    #1 reset = 1'b1;

    // Randomized passes with start/config noise while busy
    for (int p = 0; p < 8; p++) begin
      setKnobs($urandom_range(100, 40), $urandom_range(40),
               $urandom_range(50), $urandom_range(100, 40));
      startPass(GW'({$urandom, $urandom}), int'($urandom_range(6)),
                int'($urandom_range(6)), int'($urandom_range(6)),
                int'($urandom_range(6)));
      k_noise = 1'b1;
      finishPass(0, 1 << 30, 0, 1'b1);
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
